// File: rtl/debug_slave_sysclk_gen_if.sv
// ============================================================================
// Module      : debug_slave_sysclk_gen_if
// Description : JTAG-side capture inputs and system-side command outputs of
//               the debug slave system-clock generator.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface debug_slave_sysclk_gen_if #(
    parameter int IR_W  = 2,
    parameter int SR_W  = 38,
    parameter int CNT_W = 8
);
    logic [IR_W-1:0]      ir_in;
    logic [SR_W-1:0]      sr;
    logic                 vs_udr;
    logic                 vs_uir;
    logic                 cmd_ready;
    logic                 clr_overrun;
    logic [SR_W-1:0]      jdo;
    logic [IR_W-1:0]      ir_q;
    logic [(1<<IR_W)-1:0] take_action;
    logic [(1<<IR_W)-1:0] take_no_action;
    logic                 pending;
    logic                 overrun;
    logic [CNT_W-1:0]     cmd_count;

    modport slave (
        input  ir_in, sr, vs_udr, vs_uir, cmd_ready, clr_overrun,
        output jdo, ir_q, take_action, take_no_action, pending, overrun, cmd_count
    );

    modport master (
        output ir_in, sr, vs_udr, vs_uir, cmd_ready, clr_overrun,
        input  jdo, ir_q, take_action, take_no_action, pending, overrun, cmd_count
    );
endinterface

`default_nettype wire

// File: rtl/debug_slave_sysclk_gen.sv
// ============================================================================
// Module      : debug_slave_sysclk_gen
// Description : Synchronises JTAG update strobes into clk, captures the data
//               register and issues one-hot action/no-action pulses with a
//               ready handshake, overrun flag and command counter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module debug_slave_sysclk_gen #(
    parameter int IR_W        = 2,
    parameter int SR_W        = 38,
    parameter int ACT_BIT     = 37,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  wire                       clk,
    input  wire                       reset,
    debug_slave_sysclk_gen_if.slave   bus
);
    localparam int              c_CH  = 1 << IR_W;
    localparam logic [c_CH-1:0] c_ONE = {{(c_CH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] r_udr_sync;
    logic [SYNC_STAGES-1:0] r_uir_sync;
    logic                   r_udr_prev;
    logic                   r_uir_prev;
    logic [SR_W-1:0]        r_jdo;
    logic [IR_W-1:0]        r_ir_q;
    logic [IR_W-1:0]        r_ir_cmd;
    logic                   r_pending;
    logic                   r_overrun;
    logic [CNT_W-1:0]       r_cmd_count;
    logic [c_CH-1:0]        r_take_action;
    logic [c_CH-1:0]        r_take_no_action;

    logic                   w_udr_edge;
    logic                   w_uir_edge;
    logic                   w_issue;
    logic [c_CH-1:0]        w_onehot;

    assign w_udr_edge = r_udr_sync[SYNC_STAGES-1] & ~r_udr_prev;
    assign w_uir_edge = r_uir_sync[SYNC_STAGES-1] & ~r_uir_prev;
    assign w_issue    = r_pending & bus.cmd_ready;
    assign w_onehot   = c_ONE << r_ir_cmd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_udr_sync       <= '0;
            r_uir_sync       <= '0;
            r_udr_prev       <= 1'b0;
            r_uir_prev       <= 1'b0;
            r_jdo            <= '0;
            r_ir_q           <= '0;
            r_ir_cmd         <= '0;
            r_pending        <= 1'b0;
            r_overrun        <= 1'b0;
            r_cmd_count      <= '0;
            r_take_action    <= '0;
            r_take_no_action <= '0;
        end else begin
            r_udr_sync       <= {r_udr_sync[SYNC_STAGES-2:0], bus.vs_udr};
            r_uir_sync       <= {r_uir_sync[SYNC_STAGES-2:0], bus.vs_uir};
            r_udr_prev       <= r_udr_sync[SYNC_STAGES-1];
            r_uir_prev       <= r_uir_sync[SYNC_STAGES-1];
            r_take_action    <= '0;
            r_take_no_action <= '0;

            if (w_uir_edge) begin
                r_ir_q <= bus.ir_in;
            end

            // A same-cycle IR update applies to the command being captured.
            if (w_udr_edge && !r_pending) begin
                r_jdo    <= bus.sr;
                r_ir_cmd <= w_uir_edge ? bus.ir_in : r_ir_q;
            end

            if (w_udr_edge && r_pending) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_overrun) begin
                r_overrun <= 1'b0;
            end

            if (w_udr_edge && !r_pending) begin
                r_pending <= 1'b1;
            end else if (w_issue) begin
                r_pending <= 1'b0;
            end

            if (w_issue) begin
                r_cmd_count <= r_cmd_count + 1'b1;
                if (r_jdo[ACT_BIT]) begin
                    r_take_action <= w_onehot;
                end else begin
                    r_take_no_action <= w_onehot;
                end
            end
        end
    end

    assign bus.jdo            = r_jdo;
    assign bus.ir_q           = r_ir_q;
    assign bus.take_action    = r_take_action;
    assign bus.take_no_action = r_take_no_action;
    assign bus.pending        = r_pending;
    assign bus.overrun        = r_overrun;
    assign bus.cmd_count      = r_cmd_count;

endmodule

`default_nettype wire
